div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage of the MIPS datapath. It sits beside the ALU and handles the DIV/DIVU instructions, for which the ALU decoder drives a zero control code. It computes quotient and remainder with a radix-2 restoring algorithm, one bit per cycle, and stalls the pipeline through `busy` while it works. The result is a 64-bit {HI, LO} pair that goes to the HI/LO register write path.

---
 rtl/div_unit.sv | 178 +++++++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Multi-cycle integer divider for the EX stage (DIV / DIVU). It uses a
// radix-2 restoring algorithm that produces one quotient bit per cycle.
// While it works, it stalls the pipeline through `busy`.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   start       request a division (sampled only in IDLE)
//   signed_div  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   a           dividend (rs); sampled with start
//   b           divisor  (rt); sampled with start
//   annul       flush / exception; aborts any operation in progress
//   busy        stall request (combinational)
//   ready       one-cycle pulse; result is valid in the same cycle
//   result      {HI = remainder, LO = quotient}
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]       rem_q, rem_d;      // working remainder, one guard bit
    logic [WIDTH-1:0]     quo_q, quo_d;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;    // divisor magnitude
    logic                 sdiv_q, sdiv_d;
    logic                 neg_a_q, neg_a_d;  // signed op with negative dividend
    logic                 neg_b_q, neg_b_d;  // signed op with negative divisor
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Operand magnitudes: negate only for signed operations with a negative sign.
    logic                 a_neg_in, b_neg_in;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 accept;

    // One restoring step.
    logic [WIDTH+1:0]     shifted;
    logic [WIDTH+1:0]     trial;
    logic                 step_ok;
    logic [WIDTH:0]       rem_step;
    logic [WIDTH-1:0]     quo_step;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_comb begin
        a_neg_in = signed_div & a[WIDTH-1];
        b_neg_in = signed_div & b[WIDTH-1];
        a_mag    = a_neg_in ? (~a + 1'b1) : a;
        b_mag    = b_neg_in ? (~b + 1'b1) : b;
        accept   = (state_q == S_IDLE) & start & ~annul;
    end

    always_comb begin
        // rem_q < divisor always holds, so the shifted value fits in WIDTH+1
        // bits and the extra top bit makes the trial difference's sign exact.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {2'b00, dvsr_q};
        step_ok  = ~trial[WIDTH+1];
        rem_step = step_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
        quo_step = {quo_q[WIDTH-2:0], step_ok};
        quo_fix  = (sdiv_q & (neg_a_q ^ neg_b_q)) ? (~quo_step + 1'b1) : quo_step;
        rem_fix  = neg_a_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
    end

    // ---------------- state register (plus datapath flops) -------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            sdiv_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            sdiv_q   <= sdiv_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
        end
    end

    // ---------------- next-state logic ---------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (b == '0) ? S_DIVZERO : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DIVZERO: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // An abort wins over everything outside IDLE.
        if (annul && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // ---------------- datapath next values -----------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        sdiv_d   = sdiv_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;

        if (accept) begin
            sdiv_d  = signed_div;
            neg_a_d = a_neg_in;
            neg_b_d = b_neg_in;
            dvsr_d  = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            // Divide-by-zero returns the raw dividend in HI, so keep it unmodified.
            quo_d   = (b == '0) ? a : a_mag;
        end else if (!annul) begin
            if (state_q == S_RUN) begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    result_d = {rem_fix, quo_fix};
                end
            end else if (state_q == S_DIVZERO) begin
                result_d = {quo_q, {WIDTH{1'b1}}};
            end
        end
    end

    // ---------------- outputs ------------------------------------------------
    always_comb begin
        busy   = ~rst & (accept | (state_q == S_RUN) | (state_q == S_DIVZERO));
        ready  = (state_q == S_DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//
// Directed bench for div_unit. Cycle 0 is the cycle in which start is high.
// Outputs are sampled 1 ns after the falling edge, and inputs change on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int n_asserts;
    int n_fail;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one division and watches 40 cycles. The operands are scrambled
    // after the start cycle. When inject_at > 0, an extra start pulse is
    // applied in that cycle; it must be ignored.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] va,
                           input logic [31:0] vb, input logic [63:0] exp_res,
                           input int exp_ready, input int inject_at);
        int          ready_cyc;
        int          ready_cnt;
        int          busy_bad;
        logic [63:0] res_at_ready;
        ready_cyc    = -1;
        ready_cnt    = 0;
        busy_bad     = 0;
        res_at_ready = '0;
        @(negedge clk);
        start = 1'b1; signed_div = sd; a = va; b = vb; annul = 1'b0;
        #1;
        check({tag, " busy@0"}, {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a = 32'hDEAD_BEEF; b = 32'h0; signed_div = ~sd;
            end
            start = (k == inject_at);
            #1;
            if (ready === 1'b1) begin
                ready_cnt++;
                if (ready_cyc < 0) begin
                    ready_cyc    = k;
                    res_at_ready = result;
                end
            end
            if (busy !== (k < exp_ready)) busy_bad++;
        end
        start = 1'b0;
        check({tag, " ready_cycle"}, 64'(ready_cyc), 64'(exp_ready));
        check({tag, " ready_pulses"}, 64'(ready_cnt), 64'd1);
        check({tag, " busy_profile_errs"}, 64'(busy_bad), 64'd0);
        check({tag, " result@ready"}, res_at_ready, exp_res);
        check({tag, " result_held"}, result, exp_res);
        $display("txn %s: a=%h b=%h signed=%0d result=%h ready_cycle=%0d",
                 tag, va, vb, sd, res_at_ready, ready_cyc);
    endtask

    initial begin
        int pulses;
        n_asserts  = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b1;   // busy must still be low under reset
        signed_div = 1'b0;
        a          = 32'd5;
        b          = 32'd1;
        annul      = 1'b0;
        #12;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        $display("txn reset: busy=%0d ready=%0d result=%h", busy, ready, result);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        // Main function across signed and unsigned operand patterns.
        run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 0);
        run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 0);
        run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          33, 0);
        run_div("div_min_m1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          33, 0);
        run_div("divu_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},          33, 0);
        run_div("divu_min_max",1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0},          33, 0);
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},         33, 0);
        run_div("divzero",     1'b0, 32'h1234_5678,  32'd0,          {32'h1234_5678, 32'hFFFF_FFFF},  2,  0);

        // Annul in cycle 10 of a run: back to IDLE, no ready, result unchanged.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        annul = 1'b1;
        #1;
        check("annul busy@10", {63'd0, busy}, 64'd1);
        @(negedge clk);
        annul = 1'b0;
        #1;
        check("annul busy@11", {63'd0, busy}, 64'd0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (ready === 1'b1) pulses++;
        end
        check("annul ready_pulses", 64'(pulses), 64'd0);
        check("annul result_kept", result, {32'h1234_5678, 32'hFFFF_FFFF});
        $display("txn annul: busy=%0d pulses=%0d result=%h", busy, pulses, result);

        // start together with annul in IDLE is not accepted.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd0;
        #1;
        check("start+annul busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        check("start+annul not_accepted", {62'd0, busy, ready}, 64'd0);
        $display("txn start+annul: busy=%0d ready=%0d", busy, ready);

        // Normal division after the abort, with a stray start mid-run.
        run_div("post_annul_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 5);

        // Reset in cycle 5 of a run.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst busy", {63'd0, busy}, 64'd0);
        check("midrst ready", {63'd0, ready}, 64'd0);
        check("midrst result", result, 64'd0);
        $display("txn midrst: busy=%0d ready=%0d result=%h", busy, ready, result);
        @(negedge clk);
        rst = 1'b0;
        run_div("post_rst_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
